// File: rtl/stack_ctrl.sv
// LIFO stack controller driving an external single-port SRAM with one-cycle read latency.
// Pops complete through a one-cycle wait state; push/pop/clear share a fixed priority.
module stack_ctrl #(
  parameter int unsigned IA_WIDTH = 13,
  parameter int unsigned D_WIDTH  = 34
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic                clear_i,
  input  logic [D_WIDTH-1:0]  push_data_i,
  output logic                ready_o,
  output logic                pop_valid_o,
  output logic [D_WIDTH-1:0]  pop_data_o,
  output logic [IA_WIDTH:0]   count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                overflow_o,
  output logic                underflow_o,
  output logic [IA_WIDTH-1:0] mem_addr_o,
  output logic [D_WIDTH-1:0]  mem_din_o,
  output logic                mem_wren_o,
  input  logic [D_WIDTH-1:0]  mem_dout_i
);

  localparam int unsigned SP_W  = IA_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** IA_WIDTH;

  typedef enum logic {
    IDLE     = 1'b0,
    POP_WAIT = 1'b1
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [SP_W-1:0]     sp_q;
  logic [D_WIDTH-1:0]  pop_data_q;
  logic                pop_valid_q;
  logic                overflow_q;
  logic                underflow_q;

  logic                do_clear;
  logic                do_pop;
  logic                do_push;
  logic                ovf_evt;
  logic                unf_evt;

  assign count_o     = sp_q;
  assign full_o      = (sp_q == SP_W'(DEPTH));
  assign empty_o     = (sp_q == '0);
  assign pop_data_o  = pop_data_q;
  assign pop_valid_o = pop_valid_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  // Request arbitration: clear beats pop beats push; requests only count in IDLE.
  always_comb begin
    do_clear = 1'b0;
    do_pop   = 1'b0;
    do_push  = 1'b0;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    if (!reset_i && (state_q == IDLE)) begin
      if (clear_i) begin
        do_clear = 1'b1;
      end else if (pop_i) begin
        if (!empty_o) do_pop  = 1'b1;
        else          unf_evt = 1'b1;
      end else if (push_i) begin
        if (!full_o) do_push = 1'b1;
        else         ovf_evt = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (do_pop) state_d = POP_WAIT;
      POP_WAIT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output logic: SRAM port is quiet (all zero) unless a push or pop is accepted.
  always_comb begin
    ready_o    = (state_q == IDLE);
    mem_wren_o = 1'b0;
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (do_push) begin
      mem_wren_o = 1'b1;
      mem_addr_o = sp_q[IA_WIDTH-1:0];
      mem_din_o  = push_data_i;
    end else if (do_pop) begin
      // Low bits wrap correctly when sp == DEPTH (0 - 1 -> DEPTH-1).
      mem_addr_o = sp_q[IA_WIDTH-1:0] - IA_WIDTH'(1);
    end
  end

  // Stack pointer and sticky error flags
  always_ff @(posedge clk) begin
    if (reset_i) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (do_clear) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (do_push)      sp_q <= sp_q + SP_W'(1);
      else if (do_pop)  sp_q <= sp_q - SP_W'(1);
      if (ovf_evt) overflow_q  <= 1'b1;
      if (unf_evt) underflow_q <= 1'b1;
    end
  end

  // Pop result capture: SRAM data is valid during POP_WAIT.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= (state_q == POP_WAIT);
      if (state_q == POP_WAIT) pop_data_q <= mem_dout_i;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a behavioural one-cycle-latency SRAM.
module tb_stack_ctrl;

  localparam int unsigned IA = 13;
  localparam int unsigned DW = 34;
  localparam int unsigned DEPTH = 8192;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          push_i = 1'b0;
  logic          pop_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [DW-1:0] push_data_i = '0;
  logic          ready_o;
  logic          pop_valid_o;
  logic [DW-1:0] pop_data_o;
  logic [IA:0]   count_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;
  logic          underflow_o;
  logic [IA-1:0] mem_addr_o;
  logic [DW-1:0] mem_din_o;
  logic          mem_wren_o;
  logic [DW-1:0] mem_dout_i = '0;

  logic [DW-1:0] sram [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  stack_ctrl #(.IA_WIDTH(IA), .D_WIDTH(DW)) dut (
    .clk(clk), .reset_i(reset_i), .push_i(push_i), .pop_i(pop_i), .clear_i(clear_i),
    .push_data_i(push_data_i), .ready_o(ready_o), .pop_valid_o(pop_valid_o),
    .pop_data_o(pop_data_o), .count_o(count_o), .full_o(full_o), .empty_o(empty_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o), .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o), .mem_wren_o(mem_wren_o), .mem_dout_i(mem_dout_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wren_o) sram[mem_addr_o] <= mem_din_o;
    mem_dout_i <= sram[mem_addr_o];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] fill_word(input int i);
    return DW'(i) ^ 34'h2_A5A5_0000;
  endfunction

  // Drives one pop request and waits (bounded) for pop_valid_o; lat = -1 on timeout.
  task automatic pop_seq(output logic [DW-1:0] data, output int lat);
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    lat = -1;
    data = '0;
    for (int c = 1; c <= 5; c++) begin
      if (pop_valid_o) begin
        lat = c;
        data = pop_data_o;
        break;
      end
      tick();
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    push_i = 1'b1;
    push_data_i = d;
    tick();
    push_i = 1'b0;
    push_data_i = '0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    push_i = 1'b1;
    push_data_i = 34'h1_1111_1111;
    #1;
    checks++;
    if (mem_wren_o !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b want 0", mem_wren_o); end
    tick();
    tick();
    push_i = 1'b0;
    push_data_i = '0;
    reset_i = 1'b0;
    #1;
    checks++;
    if (count_o !== 14'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
      errors++; $display("FAIL reset_count: count=%0d empty=%b full=%b want 0/1/0", count_o, empty_o, full_o);
    end
    checks++;
    if (ready_o !== 1'b1 || pop_valid_o !== 1'b0 || pop_data_o !== '0) begin
      errors++; $display("FAIL reset_out: ready=%b pv=%b pd=%h want 1/0/0", ready_o, pop_valid_o, pop_data_o);
    end
    checks++;
    if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags: ovf=%b unf=%b want 0/0", overflow_o, underflow_o);
    end
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] d;
    int lat;
    push_i = 1'b1;
    push_data_i = 34'h3_0000_0001;
    #1;
    checks++;
    if (mem_wren_o !== 1'b1 || mem_addr_o !== 13'd0 || mem_din_o !== 34'h3_0000_0001) begin
      errors++; $display("FAIL push0_port: wren=%b addr=%0d din=%h want 1/0/300000001", mem_wren_o, mem_addr_o, mem_din_o);
    end
    tick();
    push_data_i = 34'h0_DEAD_BEEF;
    #1;
    checks++;
    if (mem_wren_o !== 1'b1 || mem_addr_o !== 13'd1 || mem_din_o !== 34'h0_DEAD_BEEF) begin
      errors++; $display("FAIL push1_port: wren=%b addr=%0d din=%h want 1/1/0deadbeef", mem_wren_o, mem_addr_o, mem_din_o);
    end
    tick();
    push_i = 1'b0;
    push_data_i = '0;
    #1;
    checks++;
    if (count_o !== 14'd2) begin errors++; $display("FAIL push_count: got %0d want 2", count_o); end
    pop_i = 1'b1;
    #1;
    checks++;
    if (mem_addr_o !== 13'd1 || mem_wren_o !== 1'b0) begin
      errors++; $display("FAIL pop_addr: addr=%0d wren=%b want 1/0", mem_addr_o, mem_wren_o);
    end
    pop_seq(d, lat);
    checks++;
    if (d !== 34'h0_DEAD_BEEF || lat != 2) begin
      errors++; $display("FAIL pop1: data=%h lat=%0d want 0deadbeef/2", d, lat);
    end
    checks++;
    if (count_o !== 14'd1) begin errors++; $display("FAIL pop1_count: got %0d want 1", count_o); end
    pop_seq(d, lat);
    checks++;
    if (d !== 34'h3_0000_0001 || lat != 2) begin
      errors++; $display("FAIL pop2: data=%h lat=%0d want 300000001/2", d, lat);
    end
    checks++;
    if (count_o !== 14'd0 || empty_o !== 1'b1) begin
      errors++; $display("FAIL pop2_count: count=%0d empty=%b want 0/1", count_o, empty_o);
    end
    tick();
    checks++;
    if (pop_valid_o !== 1'b0 || pop_data_o !== 34'h3_0000_0001) begin
      errors++; $display("FAIL pop_hold: pv=%b pd=%h want 0/300000001", pop_valid_o, pop_data_o);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] d;
    int lat;
    push_i = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      push_data_i = fill_word(i);
      tick();
    end
    push_i = 1'b0;
    #1;
    checks++;
    if (full_o !== 1'b1 || count_o !== 14'd8192 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL fill: full=%b count=%0d ovf=%b want 1/8192/0", full_o, count_o, overflow_o);
    end
    push_i = 1'b1;
    push_data_i = 34'h0_0BAD_0BAD;
    #1;
    checks++;
    if (mem_wren_o !== 1'b0) begin errors++; $display("FAIL ovf_wren: got %b want 0", mem_wren_o); end
    tick();
    push_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b1 || count_o !== 14'd8192) begin
      errors++; $display("FAIL ovf_flag: ovf=%b count=%0d want 1/8192", overflow_o, count_o);
    end
    pop_seq(d, lat);
    checks++;
    if (d !== fill_word(8191) || lat != 2) begin
      errors++; $display("FAIL ovf_pop: data=%h lat=%0d want %h/2", d, lat, fill_word(8191));
    end
    checks++;
    if (count_o !== 14'd8191 || overflow_o !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: count=%0d ovf=%b want 8191/1", count_o, overflow_o);
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++;
    if (count_o !== 14'd0 || overflow_o !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: count=%0d ovf=%b want 0/0", count_o, overflow_o);
    end
  endtask

  task automatic test_underflow();
    logic seen;
    pop_i = 1'b1;
    #1;
    checks++;
    if (mem_wren_o !== 1'b0 || mem_addr_o !== 13'd0) begin
      errors++; $display("FAIL unf_port: wren=%b addr=%0d want 0/0", mem_wren_o, mem_addr_o);
    end
    tick();
    pop_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (pop_valid_o !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL unf_valid: pop_valid seen=%b want 0", seen); end
    checks++;
    if (underflow_o !== 1'b1 || count_o !== 14'd0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL unf_flag: unf=%b count=%0d ready=%b want 1/0/1", underflow_o, count_o, ready_o);
    end
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    checks++;
    if (underflow_o !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b want 0", underflow_o); end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] d;
    int lat;
    push_word(34'h0_0000_1234);
    push_i = 1'b1;
    push_data_i = 34'h1_FFFF_0000;
    pop_i = 1'b1;
    #1;
    checks++;
    if (mem_wren_o !== 1'b0 || mem_addr_o !== 13'd0 || mem_din_o !== '0) begin
      errors++; $display("FAIL sim_port: wren=%b addr=%0d din=%h want 0/0/0", mem_wren_o, mem_addr_o, mem_din_o);
    end
    push_i = 1'b0;
    push_data_i = '0;
    pop_seq(d, lat);
    checks++;
    if (d !== 34'h0_0000_1234 || lat != 2 || count_o !== 14'd0) begin
      errors++; $display("FAIL sim_pop: data=%h lat=%0d count=%0d want 1234/2/0", d, lat, count_o);
    end
    push_i = 1'b1;
    clear_i = 1'b1;
    push_data_i = 34'h2_2222_2222;
    #1;
    checks++;
    if (mem_wren_o !== 1'b0) begin errors++; $display("FAIL clr_push_wren: got %b want 0", mem_wren_o); end
    tick();
    push_i = 1'b0;
    clear_i = 1'b0;
    checks++;
    if (count_o !== 14'd0) begin errors++; $display("FAIL clr_push_count: got %0d want 0", count_o); end
  endtask

  task automatic test_busy();
    push_word(34'h0_AAAA_0001);
    push_word(34'h0_BBBB_0002);
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    push_i = 1'b1;
    push_data_i = 34'h3_CCCC_0003;
    #1;
    checks++;
    if (ready_o !== 1'b0 || mem_wren_o !== 1'b0 || count_o !== 14'd1) begin
      errors++; $display("FAIL busy_wait: ready=%b wren=%b count=%0d want 0/0/1", ready_o, mem_wren_o, count_o);
    end
    tick();
    push_i = 1'b0;
    push_data_i = '0;
    checks++;
    if (pop_valid_o !== 1'b1 || pop_data_o !== 34'h0_BBBB_0002 || count_o !== 14'd1) begin
      errors++; $display("FAIL busy_pop: pv=%b pd=%h count=%0d want 1/0bbbb0002/1", pop_valid_o, pop_data_o, count_o);
    end
  endtask

  task automatic test_reset_mid_pop();
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    reset_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0 || mem_wren_o !== 1'b0) begin
      errors++; $display("FAIL rst_pop_wait: ready=%b wren=%b want 0/0", ready_o, mem_wren_o);
    end
    tick();
    reset_i = 1'b0;
    checks++;
    if (pop_valid_o !== 1'b0 || count_o !== 14'd0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_pop: pv=%b count=%0d ready=%b want 0/0/1", pop_valid_o, count_o, ready_o);
    end
    tick();
    checks++;
    if (pop_valid_o !== 1'b0 || pop_data_o !== '0) begin
      errors++; $display("FAIL rst_pop_after: pv=%b pd=%h want 0/0", pop_valid_o, pop_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_busy();
    test_reset_mid_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
